// File: rtl/dfi_phy_responder_if.sv
// DFI command/data bundle between a controller (master) and the PHY responder (slave).
// Flow is fixed-latency: no ready/backpressure signals exist on this bus.
interface dfi_phy_responder_if #(
    parameter int INTF_W = 256,
    parameter int BANK_W = 2,
    parameter int ADDR_W = 10
);
    logic                dfi__phy__cs;
    logic                dfi__phy__cmd1;
    logic                dfi__phy__cmd0;
    logic [BANK_W-1:0]   dfi__phy__bank;
    logic [ADDR_W-1:0]   dfi__phy__addr;
    logic [INTF_W-1:0]   dfi__phy__data;
    logic                phy__dfi__valid;
    logic [INTF_W-1:0]   phy__dfi__data;
    logic                phy__dfi__chan;
    logic                phy__dfi__err;
    logic [15:0]         phy__dfi__rd_cnt;
    logic [15:0]         phy__dfi__wr_cnt;

    modport master (
        output dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
               dfi__phy__bank, dfi__phy__addr, dfi__phy__data,
        input  phy__dfi__valid, phy__dfi__data, phy__dfi__chan,
               phy__dfi__err, phy__dfi__rd_cnt, phy__dfi__wr_cnt
    );

    modport slave (
        input  dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0,
               dfi__phy__bank, dfi__phy__addr, dfi__phy__data,
        output phy__dfi__valid, phy__dfi__data, phy__dfi__chan,
               phy__dfi__err, phy__dfi__rd_cnt, phy__dfi__wr_cnt
    );
endinterface

// File: rtl/dfi_phy_responder.sv
// Two-channel DFI PHY model: bank open/close tracking, per-channel storage, RD_LAT-cycle read return.
// No backpressure: every legal command is accepted on its sample edge; illegal ones set sticky err.
module dfi_phy_responder #(
    parameter int INTF_W = 256,
    parameter int BANK_W = 2,
    parameter int ADDR_W = 10,
    parameter int COL_W  = 4,
    parameter int RD_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    dfi_phy_responder_if.slave   dfi
);
    localparam int NBK   = 2 << BANK_W;
    localparam int ROW_W = ADDR_W - COL_W;
    localparam int BI_W  = BANK_W + 1;
    localparam int MI_W  = BANK_W + COL_W + 1;

    typedef struct packed {
        logic              vld;
        logic              chan;
        logic [BANK_W-1:0] bank;
        logic [COL_W-1:0]  col;
    } rd_ent_t;

    logic                r_chan;
    logic [NBK-1:0]      r_open;
    logic [ROW_W-1:0]    r_row [NBK];
    logic [INTF_W-1:0]   r_mem [1 << MI_W];
    rd_ent_t             r_pipe [RD_LAT];
    logic                r_valid;
    logic [INTF_W-1:0]   r_data;
    logic                r_rchan;
    logic                r_err;
    logic [15:0]         r_rd_cnt;
    logic [15:0]         r_wr_cnt;

    logic [1:0]          w_cmd;
    logic [BI_W-1:0]     w_bidx;
    logic [MI_W-1:0]     w_widx;
    logic                w_open;
    logic                w_pre;
    logic                w_act;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_err;
    rd_ent_t             w_fin;
    logic [MI_W-1:0]     w_ridx;
    logic [INTF_W-1:0]   w_rdat;
    logic [ROW_W-1:0]    w_row_unused;

    always_comb begin
        w_cmd   = {dfi.dfi__phy__cmd1, dfi.dfi__phy__cmd0};
        w_bidx  = {r_chan, dfi.dfi__phy__bank};
        w_widx  = {r_chan, dfi.dfi__phy__bank, dfi.dfi__phy__addr[COL_W-1:0]};
        w_open  = r_open[w_bidx];
        w_pre   = dfi.dfi__phy__cs && (w_cmd == 2'b00);
        w_act   = dfi.dfi__phy__cs && (w_cmd == 2'b01);
        w_rd_ok = dfi.dfi__phy__cs && (w_cmd == 2'b10) && w_open;
        w_wr_ok = dfi.dfi__phy__cs && (w_cmd == 2'b11) && w_open;
        w_err   = dfi.dfi__phy__cs && ((w_cmd[1] && !w_open) || (w_cmd == 2'b01 && w_open));
    end

    // Final-stage fetch forwards a same-edge write so the returned data is write-first.
    always_comb begin
        w_fin  = r_pipe[RD_LAT-1];
        w_ridx = {w_fin.chan, w_fin.bank, w_fin.col};
        w_rdat = (w_wr_ok && (w_widx == w_ridx)) ? dfi.dfi__phy__data : r_mem[w_ridx];
    end

    // Rows are tracked but alias in storage, so nothing downstream consumes them.
    always_comb begin
        w_row_unused = '0;
        for (int i = 0; i < NBK; i++) w_row_unused ^= r_row[i];
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_chan   <= 1'b0;
            r_open   <= '0;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_rchan  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_chan <= ~r_chan;
            if (w_pre) r_open[w_bidx] <= 1'b0;
            if (w_act) r_open[w_bidx] <= 1'b1;
            if (w_err) r_err <= 1'b1;
            if (w_rd_ok && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_wr_ok && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            r_pipe[0] <= '{vld:  w_rd_ok,
                           chan: r_chan,
                           bank: dfi.dfi__phy__bank,
                           col:  dfi.dfi__phy__addr[COL_W-1:0]};
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            r_valid <= w_fin.vld;
            if (w_fin.vld) begin
                r_data  <= w_rdat;
                r_rchan <= w_fin.chan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_act) r_row[w_bidx] <= dfi.dfi__phy__addr[ADDR_W-1:COL_W];
        if (w_wr_ok) r_mem[w_widx] <= dfi.dfi__phy__data;
    end

    assign dfi.phy__dfi__valid  = r_valid;
    assign dfi.phy__dfi__data   = r_data;
    assign dfi.phy__dfi__chan   = r_rchan;
    assign dfi.phy__dfi__err    = r_err;
    assign dfi.phy__dfi__rd_cnt = r_rd_cnt;
    assign dfi.phy__dfi__wr_cnt = r_wr_cnt;
endmodule
